// File: rtl/core_bus_arbiter.sv
// Purpose: lets fetch (ibus) and load/store (dbus) share one memory bus port, with one transaction outstanding at a time.
// Latency: ready in the same cycle as an IDLE request, mem_req the next cycle, rvalid/err one cycle after mem_rvalid or timeout (minimum 3 cycles).
// Backpressure: a requester holds its request until ready; mem_req is held until mem_gnt; a watchdog aborts hung transactions.
module core_bus_arbiter #(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int TIMEOUT    = 64,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst,
   // fetch requester
   input  logic            ibus_req,
   input  logic [AW-1:0]   ibus_addr,
   input  logic            ibus_kill,
   output logic            ibus_ready,
   output logic            ibus_rvalid,
   output logic [DW-1:0]   ibus_rdata,
   output logic            ibus_err,
   // load/store requester
   input  logic            dbus_req,
   input  logic            dbus_wr,
   input  logic [AW-1:0]   dbus_addr,
   input  logic [DW-1:0]   dbus_wdata,
   input  logic [DW/8-1:0] dbus_wstrb,
   output logic            dbus_ready,
   output logic            dbus_rvalid,
   output logic [DW-1:0]   dbus_rdata,
   output logic            dbus_err,
   // memory bus
   output logic            mem_req,
   output logic            mem_wr,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wstrb,
   input  logic            mem_gnt,
   input  logic            mem_rvalid,
   input  logic [DW-1:0]   mem_rdata
);

   localparam int SW  = DW / 8;
   localparam int WDW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam int SCW = $clog2(STARVE_MAX + 1);

   localparam logic [WDW-1:0] WD_LAST    = WDW'(TIMEOUT - 1);
   localparam logic [SCW-1:0] STARVE_TOP = SCW'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   // Request fields latched at accept time and presented on the bus.
   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
   } req_t;

   state_t         state_q;
   state_t         state_d;
   req_t           req_q;
   logic           owner_d_q;   // 1 = dbus owns the bus, 0 = ibus
   logic           killed_q;
   logic [WDW-1:0] wd_cnt_q;
   logic [SCW-1:0] starve_q;

   logic force_i;
   logic win_d;
   logic win_i;
   logic wd_expired;
   logic resp_done;
   logic timeout;
   logic kill_now;

   // Arbitration: dbus has priority unless ibus has been starved for STARVE_MAX grants.
   assign force_i = ibus_req && (starve_q == STARVE_TOP);
   assign win_d   = dbus_req && !force_i;
   assign win_i   = ibus_req && !win_d;

   assign wd_expired = (wd_cnt_q == WD_LAST);
   assign resp_done  = (state_q == RESP) && mem_rvalid;
   // A hang is only declared when the awaited progress event is absent in the last allowed cycle.
   assign timeout    = wd_expired &&
                       (((state_q == REQ)  && !mem_gnt) ||
                        ((state_q == RESP) && !mem_rvalid));
   // A kill arriving in the same cycle as the response still squashes the fetch result.
   assign kill_now   = killed_q || ibus_kill;

   assign mem_req   = (state_q == REQ);
   assign mem_wr    = req_q.wr;
   assign mem_addr  = req_q.addr;
   assign mem_wdata = req_q.wdata;
   assign mem_wstrb = req_q.wstrb;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and combinational accept strobes.
   always_comb begin
      state_d    = state_q;
      ibus_ready = 1'b0;
      dbus_ready = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!rst && (win_d || win_i)) begin
               dbus_ready = win_d;
               ibus_ready = win_i;
               state_d    = REQ;
            end
         end
         REQ: begin
            if (mem_gnt)      state_d = RESP;
            else if (timeout) state_d = IDLE;
         end
         RESP: begin
            if (mem_rvalid || timeout) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Latch the winner's request fields; fetches are always plain reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q <= '0;
      end else if (dbus_ready) begin
         req_q.wr    <= dbus_wr;
         req_q.addr  <= dbus_addr;
         req_q.wdata <= dbus_wdata;
         req_q.wstrb <= dbus_wstrb;
      end else if (ibus_ready) begin
         req_q.wr    <= 1'b0;
         req_q.addr  <= ibus_addr;
         req_q.wdata <= '0;
         req_q.wstrb <= '0;
      end
   end

   // Record which requester owns the outstanding transaction.
   always_ff @(posedge clk) begin
      if (rst)                           owner_d_q <= 1'b0;
      else if (ibus_ready || dbus_ready) owner_d_q <= dbus_ready;
   end

   // Track a squashed fetch from accept until the transaction retires.
   always_ff @(posedge clk) begin
      if (rst)                          killed_q <= 1'b0;
      else if (state_q == IDLE)         killed_q <= ibus_ready && ibus_kill;
      else if (state_d == IDLE)         killed_q <= 1'b0;
      else if (!owner_d_q && ibus_kill) killed_q <= 1'b1;
   end

   // Watchdog: restarts on entering REQ and on the grant, counts every busy cycle.
   always_ff @(posedge clk) begin
      if (rst)                              wd_cnt_q <= '0;
      else if (state_q == IDLE)             wd_cnt_q <= '0;
      else if (state_q == REQ && mem_gnt)   wd_cnt_q <= '0;
      else                                  wd_cnt_q <= wd_cnt_q + WDW'(1);
   end

   // Starvation counter: counts dbus wins over a waiting fetch, saturating.
   always_ff @(posedge clk) begin
      if (rst)
         starve_q <= '0;
      else if (ibus_ready)
         starve_q <= '0;
      else if (dbus_ready && ibus_req && (starve_q != STARVE_TOP))
         starve_q <= starve_q + SCW'(1);
   end

   // Completion pulses: data/ack or error back to the owner, one cycle after the bus event.
   always_ff @(posedge clk) begin
      if (rst) begin
         ibus_rvalid <= 1'b0;
         ibus_rdata  <= '0;
         ibus_err    <= 1'b0;
         dbus_rvalid <= 1'b0;
         dbus_rdata  <= '0;
         dbus_err    <= 1'b0;
      end else begin
         ibus_rvalid <= 1'b0;
         ibus_rdata  <= '0;
         ibus_err    <= 1'b0;
         dbus_rvalid <= 1'b0;
         dbus_rdata  <= '0;
         dbus_err    <= 1'b0;
         if (resp_done) begin
            if (owner_d_q) begin
               dbus_rvalid <= 1'b1;
               dbus_rdata  <= req_q.wr ? '0 : mem_rdata;
            end else if (!kill_now) begin
               ibus_rvalid <= 1'b1;
               ibus_rdata  <= mem_rdata;
            end
         end else if (timeout) begin
            if (owner_d_q)      dbus_err <= 1'b1;
            else if (!kill_now) ibus_err <= 1'b1;
         end
      end
   end

   // Only one requester may be accepted in any cycle.
   a_one_ready : assert property (@(posedge clk) disable iff (rst) !(ibus_ready && dbus_ready));
   // A requester never sees data and error together.
   a_i_excl : assert property (@(posedge clk) disable iff (rst) !(ibus_rvalid && ibus_err));
   a_d_excl : assert property (@(posedge clk) disable iff (rst) !(dbus_rvalid && dbus_err));

endmodule
